// File: rtl/program_memory.sv
// Loadable instruction store: filled through a load port while in LOAD, then locked
// and serving registered, one-cycle-latency fetches in RUN.
module program_memory #(
  parameter int unsigned       ADDR_W        = 4,
  parameter int unsigned       DATA_W        = 8,
  parameter int unsigned       DEPTH         = 16,
  parameter logic [DATA_W-1:0] DEFAULT_INSTR = DATA_W'(8'b01001111)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_done,
  input  logic [ADDR_W-1:0] ProgramCounter,
  input  logic              fetch_req,
  output logic [DATA_W-1:0] instruction,
  output logic              instr_valid,
  output logic [ADDR_W:0]   prog_len,
  output logic              running,
  output logic              load_err
);

  localparam int unsigned LEN_W = ADDR_W + 1;
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

  typedef enum logic {
    S_LOAD = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [DEPTH];

  logic             wr_en;
  logic             err_set;
  logic             fetch;
  logic             in_range;
  logic             fetch_hit;
  logic [LEN_W-1:0] addr_len;

  assign in_range  = LEN_W'(load_addr) < DEPTH_L;
  assign fetch_hit = LEN_W'(ProgramCounter) < prog_len;
  assign addr_len  = LEN_W'(load_addr) + LEN_W'(1);

  // Next-state and per-cycle action decode; writes and fetches are exclusive by state.
  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    err_set   = 1'b0;
    fetch     = 1'b0;
    case (state)
      S_LOAD: begin
        if (load_en) begin
          if (in_range) wr_en   = 1'b1;
          else          err_set = 1'b1;
        end
        if (load_done) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (load_en) err_set = 1'b1;
        fetch = fetch_req;
      end
      default: state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_LOAD;
    else       state <= state_nxt;
  end

  // Storage array: reset refills every entry with the default instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[ADDR_W'(i)] <= DEFAULT_INSTR;
    end else if (wr_en) begin
      mem[load_addr] <= load_data;
    end
  end

  // Registered outputs; prog_len only ever grows until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      instruction <= DEFAULT_INSTR;
      instr_valid <= 1'b0;
      prog_len    <= '0;
      running     <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      instr_valid <= fetch;
      if (fetch) instruction <= fetch_hit ? mem[ProgramCounter] : DEFAULT_INSTR;
      if (wr_en && (addr_len > prog_len)) prog_len <= addr_len;
      if (err_set) load_err <= 1'b1;
      running <= (state_nxt == S_RUN);
    end
  end

endmodule
